// File: rtl/seq_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen_if
// Request and serial-stream bundle for seq_pattern_gen.
//
// Signals:
//   start    request strobe, taken only while ready=1
//   pattern  PAT_W-bit pattern, LSB-aligned (bit len-1 goes out first)
//   len      pattern length (0 or >PAT_W means PAT_W)
//   reps     number of passes (0 means 1)
//   ready    generator idle and able to take a request
//   dout     current serial bit
//   dvalid   dout is valid
//   dready   downstream accepts the presented bit
//   last     final bit of the final pass is being presented
//   done     one-cycle pulse after the final bit is consumed
//
// Modports:
//   master   requester / stream sink (drives start, pattern, len, reps, dready)
//   slave    the generator itself
// -----------------------------------------------------------------------------
interface seq_pattern_gen_if #(
   parameter int PAT_W = 6,
   parameter int LEN_W = 3,
   parameter int CNT_W = 8
);
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] reps;
   logic             ready;
   logic             dout;
   logic             dvalid;
   logic             dready;
   logic             last;
   logic             done;

   modport master (
      output start, pattern, len, reps, dready,
      input  ready, dout, dvalid, last, done
   );

   modport slave (
      input  start, pattern, len, reps, dready,
      output ready, dout, dvalid, last, done
   );
endinterface

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
// Serial bit-pattern transmitter. Latches a pattern of up to PAT_W bits and a
// repetition count, then sends the active window MSB first over a
// valid/ready bit stream, once per pass.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (forces IDLE, ready=1)
//   bus    seq_pattern_gen_if.slave: start/pattern/len/reps request side,
//          ready status, dout/dvalid/dready/last stream, done pulse
//
// Parameters:
//   PAT_W  maximum pattern length
//   LEN_W  width of len (2**LEN_W must exceed PAT_W)
//   CNT_W  width of reps
//   GAP    idle cycles between passes (1..15), only with SEQGEN_GAP_EN
//
// Build option:
//   SEQGEN_GAP_EN  when defined, inserts GAP cycles with dvalid=0 between
//                  consecutive passes; undefined, passes run back-to-back.
//
// Every output is a flop; next output values are decided alongside the next
// state so nothing on the inputs reaches an output combinationally.
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
   parameter int PAT_W = 6,
   parameter int LEN_W = 3,
   parameter int CNT_W = 8,
   parameter int GAP   = 2
) (
   input  logic               clk,
   input  logic               reset,
   seq_pattern_gen_if.slave   bus
);

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifndef SEQGEN_GAP_EN
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
`endif

   // Elaboration-time parameter sanity checks.
   if ((1 << LEN_W) <= PAT_W) begin : g_bad_len_w
      $error("seq_pattern_gen: 2**LEN_W must exceed PAT_W");
   end
   if ((GAP < 1) || (GAP > 15)) begin : g_bad_gap
      $error("seq_pattern_gen: GAP must be in 1..15");
   end

`ifdef SEQGEN_GAP_EN
   // The counter starts at GAP-1 and leaves GAP when it reads zero, giving
   // exactly GAP idle cycles.
   localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
`ifdef SEQGEN_GAP_EN
      ST_GAP  = 2'd2,
`endif
      ST_DONE = 2'd3
   } state_t;

   state_t           state_r;
   logic [PAT_W-1:0] pat_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] idx_r;
   logic [CNT_W-1:0] pass_r;
`ifdef SEQGEN_GAP_EN
   logic [3:0]       gap_cnt_r;
`endif
   logic             ready_r;
   logic             dout_r;
   logic             dvalid_r;
   logic             last_r;
   logic             done_r;

   logic [LEN_W-1:0] len_eff_s;
   logic [CNT_W-1:0] reps_eff_s;
   logic [LEN_W-1:0] start_idx_s;
   logic [LEN_W-1:0] reload_idx_s;
   logic [LEN_W-1:0] next_idx_s;

   // Clamp the requested length/reps and precompute the bit indices used next.
   always_comb begin
      len_eff_s    = LEN_MAX;
      reps_eff_s   = CNT_ONE;
      if ((bus.len == LEN_ZERO) || (bus.len > LEN_MAX)) begin
         len_eff_s = LEN_MAX;
      end else begin
         len_eff_s = bus.len;
      end
      if (bus.reps == CNT_ZERO) begin
         reps_eff_s = CNT_ONE;
      end else begin
         reps_eff_s = bus.reps;
      end
      start_idx_s  = len_eff_s - LEN_ONE;
      reload_idx_s = len_r - LEN_ONE;
      next_idx_s   = idx_r - LEN_ONE;
   end

   // Control FSM with registered stream outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         pat_r     <= {PAT_W{1'b0}};
         len_r     <= LEN_ZERO;
         idx_r     <= LEN_ZERO;
         pass_r    <= CNT_ZERO;
`ifdef SEQGEN_GAP_EN
         gap_cnt_r <= 4'd0;
`endif
         ready_r   <= 1'b1;
         dout_r    <= 1'b0;
         dvalid_r  <= 1'b0;
         last_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  pat_r    <= bus.pattern;
                  len_r    <= len_eff_s;
                  idx_r    <= start_idx_s;
                  pass_r   <= reps_eff_s;
                  ready_r  <= 1'b0;
                  dvalid_r <= 1'b1;
                  dout_r   <= bus.pattern[start_idx_s];
                  last_r   <= (start_idx_s == LEN_ZERO) && (reps_eff_s == CNT_ONE);
                  state_r  <= ST_SEND;
               end else begin
                  ready_r  <= 1'b1;
                  dvalid_r <= 1'b0;
                  dout_r   <= 1'b0;
                  last_r   <= 1'b0;
               end
            end

            ST_SEND: begin
               if (bus.dready) begin
                  if (idx_r != LEN_ZERO) begin
                     idx_r  <= next_idx_s;
                     dout_r <= pat_r[next_idx_s];
                     last_r <= (next_idx_s == LEN_ZERO) && (pass_r == CNT_ONE);
                  end else if (pass_r != CNT_ONE) begin
                     pass_r <= pass_r - CNT_ONE;
                     idx_r  <= reload_idx_s;
`ifdef SEQGEN_GAP_EN
                     gap_cnt_r <= GAP_LOAD;
                     dvalid_r  <= 1'b0;
                     dout_r    <= 1'b0;
                     last_r    <= 1'b0;
                     state_r   <= ST_GAP;
`else
                     // Next pass starts on the very next cycle; it is the
                     // final one when the counter is about to drop to 1.
                     dout_r <= pat_r[reload_idx_s];
                     last_r <= (reload_idx_s == LEN_ZERO) && (pass_r == CNT_TWO);
`endif
                  end else begin
                     dvalid_r <= 1'b0;
                     dout_r   <= 1'b0;
                     last_r   <= 1'b0;
                     done_r   <= 1'b1;
                     state_r  <= ST_DONE;
                  end
               end else begin
                  // Backpressure: the presented bit and all counters hold.
                  dvalid_r <= 1'b1;
               end
            end

`ifdef SEQGEN_GAP_EN
            ST_GAP: begin
               if (gap_cnt_r == 4'd0) begin
                  dvalid_r <= 1'b1;
                  dout_r   <= pat_r[idx_r];
                  last_r   <= (idx_r == LEN_ZERO) && (pass_r == CNT_ONE);
                  state_r  <= ST_SEND;
               end else begin
                  gap_cnt_r <= gap_cnt_r - 4'd1;
               end
            end
`endif

            ST_DONE: begin
               done_r  <= 1'b0;
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end

            default: begin
               state_r  <= ST_IDLE;
               ready_r  <= 1'b1;
               dout_r   <= 1'b0;
               dvalid_r <= 1'b0;
               last_r   <= 1'b0;
               done_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready  = ready_r;
   assign bus.dout   = dout_r;
   assign bus.dvalid = dvalid_r;
   assign bus.last   = last_r;
   assign bus.done   = done_r;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
// Self-checking bench for seq_pattern_gen. The reference model expands a
// request into the bit sequence it must produce (pass by pass, MSB of the
// window first) and derives timing from the stream rules; observations are
// gathered on the falling edge and compared in each scenario task.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

   localparam int PAT_W = 6;
   localparam int LEN_W = 3;
   localparam int CNT_W = 8;
   localparam int GAP   = 2;
`ifdef SEQGEN_GAP_EN
   localparam int GAP_EXP = GAP;
`else
   localparam int GAP_EXP = 0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seq_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   seq_pattern_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Observations from the most recent transfer.
   logic obs_bits[$];
   logic obs_last[$];
   int   obs_gap[$];
   int   obs_first, obs_done, obs_ready, obs_pulses, obs_stalls, obs_hold_bad, obs_bad;

   // Reference model output.
   logic exp_bits[$];
   int   exp_gap[$];
   int   exp_cycles;

   function automatic int eff_len(input logic [2:0] len);
      if ((len == 3'd0) || (len > 3'd6)) return 6;
      return int'(len);
   endfunction

   function automatic int eff_reps(input logic [7:0] reps);
      if (reps == 8'd0) return 1;
      return int'(reps);
   endfunction

   task automatic build_expected(input logic [5:0] pat, input logic [2:0] len, input logic [7:0] reps);
      int l;
      int r;
      l = eff_len(len);
      r = eff_reps(reps);
      exp_bits.delete();
      exp_gap.delete();
      for (int p = 0; p < r; p++) begin
         for (int i = l - 1; i >= 0; i--) begin
            exp_bits.push_back(pat[i]);
            exp_gap.push_back(((p > 0) && (i == l - 1)) ? GAP_EXP : 0);
         end
      end
      // Cycle on which done is seen, counting from cycle 1 = first bit, no stalls.
      exp_cycles = l * r + GAP_EXP * (r - 1) + 1;
   endtask

   // Issue one request and record the stream until ready returns.
   task automatic capture(input logic [5:0] pat, input logic [2:0] len, input logic [7:0] reps,
                          input int stall_pct, input int stall_at, input int stall_len, input int pulse_at);
      int   cyc;
      int   inval;
      int   stall_left;
      bit   stall_used;
      bit   prev_stalled;
      logic prev_dout;
      logic prev_last;
      bit   dr;
      obs_bits.delete();
      obs_last.delete();
      obs_gap.delete();
      obs_first = -1; obs_done = -1; obs_ready = -1;
      obs_pulses = 0; obs_stalls = 0; obs_hold_bad = 0; obs_bad = 0;
      inval = 0; stall_left = 0; stall_used = 1'b0; prev_stalled = 1'b0;
      prev_dout = 1'b0; prev_last = 1'b0;
      bus.start   = 1'b1;
      bus.pattern = pat;
      bus.len     = len;
      bus.reps    = reps;
      bus.dready  = 1'b0;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.pattern = 6'($urandom);
      bus.len     = 3'($urandom);
      bus.reps    = 8'($urandom);
      cyc = 0;
      while (cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == pulse_at);
         if (bus.ready) begin
            obs_ready = cyc;
            break;
         end
         if (bus.done) begin
            obs_pulses++;
            if (obs_done < 0) obs_done = cyc;
         end
         if (prev_stalled && (!bus.dvalid || (bus.dout !== prev_dout) || (bus.last !== prev_last)))
            obs_hold_bad++;
         if (bus.dvalid) begin
            if (obs_first < 0) obs_first = cyc;
            if (stall_left > 0) begin
               dr = 1'b0;
               stall_left--;
            end else if (!stall_used && (stall_len > 0) && (obs_bits.size() == stall_at)) begin
               dr = 1'b0;
               stall_used = 1'b1;
               stall_left = stall_len - 1;
            end else begin
               dr = ($urandom_range(99) >= stall_pct);
            end
            bus.dready   = dr;
            prev_stalled = !dr;
            prev_dout    = bus.dout;
            prev_last    = bus.last;
            if (dr) begin
               obs_bits.push_back(bus.dout);
               obs_last.push_back(bus.last);
               obs_gap.push_back(inval);
               inval = 0;
            end else begin
               obs_stalls++;
            end
         end else begin
            prev_stalled = 1'b0;
            bus.dready   = 1'($urandom_range(1));
            if ((bus.dout !== 1'b0) || (bus.last !== 1'b0)) obs_bad++;
            if ((obs_bits.size() > 0) && (obs_done < 0)) inval++;
         end
      end
      bus.start  = 1'b0;
      bus.dready = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.pattern = 6'd0; bus.len = 3'd0; bus.reps = 8'd0; bus.dready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.ready, bus.dout, bus.dvalid, bus.last, bus.done} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 10000", {bus.ready, bus.dout, bus.dvalid, bus.last, bus.done});
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.dout, bus.dvalid, bus.last, bus.done} !== 5'b10000) begin
         errors++;
         $display("FAIL idle_outputs: got %b expected 10000", {bus.ready, bus.dout, bus.dvalid, bus.last, bus.done});
      end
   endtask

   task automatic test_basic();
      logic [5:0] want;
      want = 6'b101010;
      capture(6'b101010, 3'd6, 8'd1, 0, -1, 0, -1);
      checks++;
      if (obs_first != 1) begin errors++; $display("FAIL basic_first_cycle: got %0d expected 1", obs_first); end
      checks++;
      if (obs_bits.size() != 6) begin
         errors++; $display("FAIL basic_bit_count: got %0d expected 6", obs_bits.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if ((obs_bits[i] !== want[5-i]) || (obs_last[i] !== (i == 5))) begin
               errors++;
               $display("FAIL basic_bit%0d: got dout=%b last=%b expected dout=%b last=%b",
                        i, obs_bits[i], obs_last[i], want[5-i], (i == 5));
            end
         end
      end
      checks++;
      if ((obs_done != 7) || (obs_ready != 8) || (obs_pulses != 1)) begin
         errors++;
         $display("FAIL basic_done_timing: got done@%0d ready@%0d pulses=%0d expected 7 8 1", obs_done, obs_ready, obs_pulses);
      end
      checks++;
      if (obs_bad != 0) begin errors++; $display("FAIL basic_idle_outputs: got %0d bad cycles expected 0", obs_bad); end
   endtask

   task automatic test_repeat();
      build_expected(6'b101010, 3'd6, 8'd3);
      capture(6'b101010, 3'd6, 8'd3, 0, -1, 0, -1);
      checks++;
      if (obs_bits.size() != 18) begin
         errors++; $display("FAIL repeat_bit_count: got %0d expected 18", obs_bits.size());
      end else begin
         for (int i = 0; i < 18; i++) begin
            checks++;
            if ((obs_bits[i] !== exp_bits[i]) || (obs_last[i] !== (i == 17)) || (obs_gap[i] != exp_gap[i])) begin
               errors++;
               $display("FAIL repeat_bit%0d: got dout=%b last=%b gap=%0d expected dout=%b last=%b gap=%0d",
                        i, obs_bits[i], obs_last[i], obs_gap[i], exp_bits[i], (i == 17), exp_gap[i]);
            end
         end
      end
      checks++;
      if ((obs_done != exp_cycles) || (obs_pulses != 1) || (obs_ready != exp_cycles + 1)) begin
         errors++;
         $display("FAIL repeat_done: got done@%0d pulses=%0d ready@%0d expected %0d 1 %0d",
                  obs_done, obs_pulses, obs_ready, exp_cycles, exp_cycles + 1);
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] want;
      want = 6'b101010;
      capture(6'b101010, 3'd6, 8'd1, 0, 1, 3, -1);
      checks++;
      if ((obs_stalls != 3) || (obs_hold_bad != 0)) begin
         errors++;
         $display("FAIL bp_hold: got stalls=%0d hold_violations=%0d expected 3 0", obs_stalls, obs_hold_bad);
      end
      checks++;
      if (obs_bits.size() != 6) begin
         errors++; $display("FAIL bp_bit_count: got %0d expected 6", obs_bits.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_bits[i] !== want[5-i]) begin
               errors++; $display("FAIL bp_bit%0d: got %b expected %b", i, obs_bits[i], want[5-i]);
            end
         end
      end
      checks++;
      if ((obs_done != 10) || (obs_ready != 11)) begin
         errors++; $display("FAIL bp_done: got done@%0d ready@%0d expected 10 11", obs_done, obs_ready);
      end
   endtask

   task automatic test_clamp();
      logic [2:0] lens [2];
      logic [5:0] want;
      lens[0] = 3'd0;
      lens[1] = 3'd7;
      want = 6'b110001;
      for (int k = 0; k < 2; k++) begin
         capture(6'b110001, lens[k], 8'd0, 0, -1, 0, -1);
         checks++;
         if (obs_bits.size() != 6) begin
            errors++; $display("FAIL clamp_len%0d_count: got %0d expected 6", lens[k], obs_bits.size());
         end else begin
            for (int i = 0; i < 6; i++) begin
               checks++;
               if ((obs_bits[i] !== want[5-i]) || (obs_last[i] !== (i == 5))) begin
                  errors++;
                  $display("FAIL clamp_len%0d_bit%0d: got dout=%b last=%b expected dout=%b last=%b",
                           lens[k], i, obs_bits[i], obs_last[i], want[5-i], (i == 5));
               end
            end
         end
         checks++;
         if ((obs_done != 7) || (obs_pulses != 1)) begin
            errors++; $display("FAIL clamp_len%0d_done: got done@%0d pulses=%0d expected 7 1", lens[k], obs_done, obs_pulses);
         end
      end
   endtask

   task automatic test_abort();
      int bad;
      bus.start = 1'b1; bus.pattern = 6'b101010; bus.len = 3'd6; bus.reps = 8'd2; bus.dready = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if ((bus.dout !== 1'b1) || (bus.dvalid !== 1'b1)) begin
         errors++; $display("FAIL abort_bit1: got dout=%b dvalid=%b expected 1 1", bus.dout, bus.dvalid);
      end
      // A second request while sending must be ignored.
      bus.start = 1'b1; bus.pattern = 6'b111111; bus.len = 3'd6; bus.reps = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if ((bus.dout !== 1'b0) || (bus.dvalid !== 1'b1) || (bus.ready !== 1'b0)) begin
         errors++; $display("FAIL ignore_start: got dout=%b dvalid=%b ready=%b expected 0 1 0", bus.dout, bus.dvalid, bus.ready);
      end
      @(negedge clk);
      checks++;
      if (bus.dout !== 1'b1) begin errors++; $display("FAIL abort_bit3: got %b expected 1", bus.dout); end
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.ready, bus.dout, bus.dvalid, bus.last, bus.done} !== 5'b10000) begin
         errors++; $display("FAIL abort_reset: got %b expected 10000", {bus.ready, bus.dout, bus.dvalid, bus.last, bus.done});
      end
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if ((bus.ready !== 1'b1) || (bus.dvalid !== 1'b0) || (bus.done !== 1'b0)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL abort_no_replay: got %0d busy cycles expected 0", bad); end
      capture(6'b000101, 3'd3, 8'd1, 0, -1, 0, -1);
      checks++;
      if ((obs_bits.size() != 3) || (obs_bits[0] !== 1'b1) || (obs_bits[1] !== 1'b0) || (obs_bits[2] !== 1'b1)) begin
         errors++; $display("FAIL abort_restart_stream: got %0d bits %p expected 3 bits 1,0,1", obs_bits.size(), obs_bits);
      end
      checks++;
      if ((obs_done != 4) || (obs_ready != 5)) begin
         errors++; $display("FAIL abort_restart_done: got done@%0d ready@%0d expected 4 5", obs_done, obs_ready);
      end
   endtask

   task automatic test_gap();
      // Three-bit pattern, two passes: gap length between passes follows the build.
      build_expected(6'b000110, 3'd3, 8'd2);
      capture(6'b000110, 3'd3, 8'd2, 0, -1, 0, -1);
      checks++;
      if (obs_bits.size() != 6) begin
         errors++; $display("FAIL gap_bit_count: got %0d expected 6", obs_bits.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if ((obs_bits[i] !== exp_bits[i]) || (obs_gap[i] != exp_gap[i]) || (obs_last[i] !== (i == 5))) begin
               errors++;
               $display("FAIL gap_bit%0d: got dout=%b gap=%0d last=%b expected dout=%b gap=%0d last=%b",
                        i, obs_bits[i], obs_gap[i], obs_last[i], exp_bits[i], exp_gap[i], (i == 5));
            end
         end
      end
      checks++;
      if ((obs_done != exp_cycles) || (obs_pulses != 1)) begin
         errors++; $display("FAIL gap_done: got done@%0d pulses=%0d expected %0d 1", obs_done, obs_pulses, exp_cycles);
      end
   endtask

   task automatic test_back_to_back();
      capture(6'b111000, 3'd6, 8'd1, 0, -1, 0, -1);
      checks++;
      if (obs_ready != 8) begin errors++; $display("FAIL b2b_first_ready: got %0d expected 8", obs_ready); end
      build_expected(6'b000011, 3'd2, 8'd2);
      capture(6'b000011, 3'd2, 8'd2, 0, -1, 0, -1);
      checks++;
      if ((obs_bits.size() != 4) || (obs_first != 1) || (obs_done != exp_cycles)) begin
         errors++;
         $display("FAIL b2b_second: got %0d bits first@%0d done@%0d expected 4 1 %0d", obs_bits.size(), obs_first, obs_done, exp_cycles);
      end
   endtask

   task automatic test_random();
      logic [5:0] pat;
      logic [2:0] len;
      logic [7:0] reps;
      int         pct;
      int         pulse;
      for (int t = 0; t < 30; t++) begin
         pat   = 6'($urandom);
         len   = 3'($urandom_range(7));
         reps  = 8'($urandom_range(4));
         pct   = $urandom_range(50);
         pulse = ($urandom_range(1) == 1) ? 2 : -1;
         build_expected(pat, len, reps);
         capture(pat, len, reps, pct, -1, 0, pulse);
         checks++;
         if (obs_bits.size() != exp_bits.size()) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d expected %0d (pat=%b len=%0d reps=%0d)", t, obs_bits.size(), exp_bits.size(), pat, len, reps);
         end else begin
            for (int i = 0; i < exp_bits.size(); i++) begin
               checks++;
               if ((obs_bits[i] !== exp_bits[i]) || (obs_last[i] !== (i == exp_bits.size() - 1)) || (obs_gap[i] != exp_gap[i])) begin
                  errors++;
                  $display("FAIL rand%0d_bit%0d: got dout=%b last=%b gap=%0d expected dout=%b last=%b gap=%0d",
                           t, i, obs_bits[i], obs_last[i], obs_gap[i], exp_bits[i], (i == exp_bits.size() - 1), exp_gap[i]);
               end
            end
         end
         checks++;
         if ((obs_done != exp_cycles + obs_stalls) || (obs_ready != obs_done + 1) || (obs_pulses != 1)) begin
            errors++;
            $display("FAIL rand%0d_done: got done@%0d ready@%0d pulses=%0d expected %0d %0d 1",
                     t, obs_done, obs_ready, obs_pulses, exp_cycles + obs_stalls, exp_cycles + obs_stalls + 1);
         end
         checks++;
         if ((obs_hold_bad != 0) || (obs_bad != 0) || (obs_first != 1)) begin
            errors++;
            $display("FAIL rand%0d_protocol: got hold=%0d idle_bad=%0d first@%0d expected 0 0 1", t, obs_hold_bad, obs_bad, obs_first);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_repeat();
      test_backpressure();
      test_clamp();
      test_abort();
      test_gap();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
